// File: rtl/jtagwordser_pkg.sv
// Shared definitions for the JTAG word bridge: frame bit positions, the idle
// TX frame pattern and the classification of a sampled TCK rising edge.
package jtagser_pkg;

  localparam int FLAG_BIT = 0;
  localparam int DATA_LSB = 1;

  // Wide enough for any practical DW; the top slices off the frame width it needs.
  localparam int MAX_FW = 65;
  localparam logic [MAX_FW-1:0] IDLE_FRAME_MAX = {{(MAX_FW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_CAPTURE,
    EDGE_SHIFT,
    EDGE_ABORT
  } jtag_edge_e;

endpackage

// File: rtl/jtagwordser_sfifo.sv
// Synchronous first-word-fall-through FIFO with fill level; writes while full
// and reads while empty are dropped.
module sfifo #(
  parameter int DW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [DW-1:0]     i_wr_data,
  input  logic              i_rd,
  output logic [DW-1:0]     o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_fill
);

  logic [LGFLEN:0] wptr_q, wptr_d;
  logic [LGFLEN:0] rptr_q, rptr_d;
  logic [DW-1:0]   mem_q [0:(1<<LGFLEN)-1];
  logic            wr_ok, rd_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_fill    = wptr_q - rptr_q;
  assign o_full    = o_fill[LGFLEN];
  assign o_empty   = (o_fill == '0);
  assign o_rd_data = o_empty ? '0 : mem_q[rptr_q[LGFLEN-1:0]];

  always_comb begin
    wr_ok  = i_wr && !o_full;
    rd_ok  = i_rd && !o_empty;
    wptr_d = wr_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_ok ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem_q[wptr_q[LGFLEN-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/jtagwordser.sv
// Bridges BSCAN USER-chain DR shifts to DW-bit words framed with a valid flag,
// buffered through TX and RX FIFOs; all JTAG pins are oversampled on i_clk.
module jtagwordser
  import jtagser_pkg::*;
#(
  parameter int DW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_jtck,
  input  logic              i_jtdi,
  input  logic              i_jsel,
  input  logic              i_jshift,
  input  logic              i_jcapture,
  output logic              o_jtdo,
  input  logic              i_tx_wr,
  input  logic [DW-1:0]     i_tx_data,
  output logic              o_tx_full,
  output logic [LGFLEN:0]   o_tx_fill,
  input  logic              i_rx_rd,
  output logic [DW-1:0]     o_rx_data,
  output logic              o_rx_empty,
  input  logic              i_rx_ovclr,
  output logic              o_rx_overflow
);

  localparam int FW = DW + 1;
  localparam int CW = $clog2(FW);
  localparam logic [FW-1:0]   IDLE_FRAME = IDLE_FRAME_MAX[FW-1:0];
  localparam logic [CW-1:0]   LAST_BIT   = CW'(FW - 1);
  localparam logic [LGFLEN:0] DEPTH      = (LGFLEN+1)'(1 << LGFLEN);

  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic       tck_prev_q, tck_prev_d, tck_rise_q, tck_rise_d;
  logic       tdi_q, sel_q, shift_q, capture_q;
  logic [3:0] ctl_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-2:0] rx_sr_q, rx_sr_d;
  logic [FW-2:0] tx_sr_q, tx_sr_d;
  logic          jtdo_q, jtdo_d;
  logic          ovf_q, ovf_d;

  jtag_edge_e    edge_kind;
  logic [FW-1:0] rx_frame, tx_frame;
  logic          rx_push, ovf_set, reload, tx_pop;
  logic          tx_empty, rx_full, rx_room;
  logic [DW-1:0] tx_head;
  logic [LGFLEN:0] rx_fill;

  // The control lines ride the same pipeline as TCK so they line up with tck_rise.
  always_comb begin
    sync1_d    = {i_jcapture, i_jshift, i_jsel, i_jtdi, i_jtck};
    sync2_d    = sync1_q;
    tck_prev_d = sync2_q[0];
    tck_rise_d = sync2_q[0] & ~tck_prev_q;
    ctl_d      = sync2_q[4:1];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tck_prev_q <= 1'b0;
      tck_rise_q <= 1'b0;
      {capture_q, shift_q, sel_q, tdi_q} <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tck_prev_q <= tck_prev_d;
      tck_rise_q <= tck_rise_d;
      {capture_q, shift_q, sel_q, tdi_q} <= ctl_d;
    end
  end

  always_comb begin
    edge_kind = EDGE_NONE;
    if (tck_rise_q && sel_q) begin
      if (capture_q)    edge_kind = EDGE_CAPTURE;
      else if (shift_q) edge_kind = EDGE_SHIFT;
      else              edge_kind = EDGE_ABORT;
    end
  end

  assign rx_room = (rx_fill != DEPTH) && !rx_full;

  always_comb begin
    cnt_d    = cnt_q;
    rx_sr_d  = rx_sr_q;
    tx_sr_d  = tx_sr_q;
    jtdo_d   = jtdo_q;
    rx_frame = {tdi_q, rx_sr_q};
    tx_frame = IDLE_FRAME;
    rx_push  = 1'b0;
    ovf_set  = 1'b0;
    reload   = 1'b0;
    tx_pop   = 1'b0;
    case (edge_kind)
      EDGE_CAPTURE: begin
        cnt_d   = '0;
        rx_sr_d = '0;
        reload  = 1'b1;
      end
      EDGE_SHIFT: begin
        rx_sr_d = rx_frame[FW-1:1];
        tx_sr_d = {1'b1, tx_sr_q[FW-2:1]};
        jtdo_d  = tx_sr_q[0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d  = '0;
          reload = 1'b1;
          if (rx_frame[FLAG_BIT]) begin
            if (rx_room) rx_push = 1'b1;
            else         ovf_set = 1'b1;
          end
        end
      end
      EDGE_ABORT: begin
        cnt_d   = '0;
        rx_sr_d = '0;
      end
      default: ;
    endcase
    // Frame bit 0 goes straight to TDO; the rest waits in the shift register.
    if (reload) begin
      tx_pop   = !tx_empty;
      tx_frame = tx_empty ? IDLE_FRAME : {tx_head, 1'b1};
      tx_sr_d  = tx_frame[FW-1:DATA_LSB];
      jtdo_d   = tx_frame[FLAG_BIT];
    end
    ovf_d = ovf_set | (ovf_q & ~i_rx_ovclr);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      rx_sr_q <= '0;
      tx_sr_q <= '0;
      jtdo_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rx_sr_q <= rx_sr_d;
      tx_sr_q <= tx_sr_d;
      jtdo_q  <= jtdo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_jtdo        = jtdo_q;
  assign o_rx_overflow = ovf_q;

  sfifo #(.DW(DW), .LGFLEN(LGFLEN)) u_tx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr      (i_tx_wr),
    .i_wr_data (i_tx_data),
    .i_rd      (tx_pop),
    .o_rd_data (tx_head),
    .o_full    (o_tx_full),
    .o_empty   (tx_empty),
    .o_fill    (o_tx_fill)
  );

  sfifo #(.DW(DW), .LGFLEN(LGFLEN)) u_rx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr      (rx_push),
    .i_wr_data (rx_frame[FW-1:DATA_LSB]),
    .i_rd      (i_rx_rd),
    .o_rd_data (o_rx_data),
    .o_full    (rx_full),
    .o_empty   (o_rx_empty),
    .o_fill    (rx_fill)
  );

endmodule

// File: tb/tb_jtagwordser.sv
// Directed-plus-random bench for jtagwordser: drives JTAG edges at a 16x clock
// ratio and checks against queue-based TX/RX models kept at frame level.
module tb_jtagwordser;

  localparam int DW     = 8;
  localparam int LGFLEN = 2;
  localparam int DEPTH  = 1 << LGFLEN;
  localparam int FW     = DW + 1;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              jtck = 1'b0, jtdi = 1'b0, jsel = 1'b0, jshift = 1'b0, jcapture = 1'b0;
  logic              jtdo;
  logic              txWr = 1'b0;
  logic [DW-1:0]     txData = '0;
  logic              txFull;
  logic [LGFLEN:0]   txFill;
  logic              rxRd = 1'b0;
  logic [DW-1:0]     rxData;
  logic              rxEmpty;
  logic              rxOvclr = 1'b0;
  logic              rxOverflow;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] txModel[$];
  logic [DW-1:0] rxModel[$];
  logic          ovfModel = 1'b0;
  logic [FW-1:0] expFrame;

  jtagwordser #(.DW(DW), .LGFLEN(LGFLEN)) dut (
    .i_clk         (clk),
    .i_reset_n     (resetN),
    .i_jtck        (jtck),
    .i_jtdi        (jtdi),
    .i_jsel        (jsel),
    .i_jshift      (jshift),
    .i_jcapture    (jcapture),
    .o_jtdo        (jtdo),
    .i_tx_wr       (txWr),
    .i_tx_data     (txData),
    .o_tx_full     (txFull),
    .o_tx_fill     (txFill),
    .i_rx_rd       (rxRd),
    .o_rx_data     (rxData),
    .o_rx_empty    (rxEmpty),
    .i_rx_ovclr    (rxOvclr),
    .o_rx_overflow (rxOverflow)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (50000) @(posedge clk);
    $display("[TB] FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // One full TCK period (8 clocks high, 8 low) with the given BSCAN levels.
  task automatic applyStimulus(input logic tdi, input logic sel, input logic shift, input logic capture);
    @(negedge clk);
    jtdi = tdi; jsel = sel; jshift = shift; jcapture = capture; jtck = 1'b1;
    repeat (8) @(negedge clk);
    jtck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic modelReload();
    if (txModel.size() > 0) expFrame = {txModel.pop_front(), 1'b1};
    else                    expFrame = {{DW{1'b1}}, 1'b0};
  endtask

  task automatic doCapture();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    modelReload();
  endtask

  task automatic hostFrame(input logic [FW-1:0] frame, input bit checkTdo, input string tag);
    logic [FW-1:0] tdoBits;
    for (int i = 0; i < FW; i++) begin
      tdoBits[i] = jtdo;
      applyStimulus(frame[i], 1'b1, 1'b1, 1'b0);
    end
    if (checkTdo) checkOutput({tag, "_tdo"}, 32'(tdoBits), 32'(expFrame));
    if (frame[0]) begin
      if (rxModel.size() < DEPTH) rxModel.push_back(frame[FW-1:1]);
      else                        ovfModel = 1'b1;
    end
    modelReload();
    checkOutput({tag, "_txfill"}, 32'(txFill), txModel.size());
  endtask

  task automatic txWrite(input logic [DW-1:0] data, input string tag);
    @(negedge clk);
    txWr = 1'b1; txData = data;
    @(negedge clk);
    txWr = 1'b0;
    if (txModel.size() < DEPTH) txModel.push_back(data);
    checkOutput({tag, "_fill"}, 32'(txFill), txModel.size());
    checkOutput({tag, "_full"}, 32'(txFull), 32'(txModel.size() == DEPTH));
  endtask

  task automatic rxCheckPop(input string tag);
    if (rxModel.size() > 0) begin
      checkOutput({tag, "_empty"}, 32'(rxEmpty), 32'd0);
      checkOutput({tag, "_data"}, 32'(rxData), 32'(rxModel[0]));
      @(negedge clk); rxRd = 1'b1;
      @(negedge clk); rxRd = 1'b0;
      void'(rxModel.pop_front());
    end else begin
      checkOutput({tag, "_empty"}, 32'(rxEmpty), 32'd1);
    end
  endtask

  // Capture edge with a TX write landing on the very cycle the empty TX FIFO is probed.
  task automatic captureWithWrite(input logic [DW-1:0] data);
    @(negedge clk);
    jtdi = 1'b0; jsel = 1'b1; jshift = 1'b0; jcapture = 1'b1; jtck = 1'b1;
    repeat (3) @(negedge clk);
    txWr = 1'b1; txData = data;
    @(negedge clk);
    txWr = 1'b0;
    repeat (4) @(negedge clk);
    jtck = 1'b0;
    repeat (8) @(negedge clk);
    modelReload();
    txModel.push_back(data);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [FW-1:0] partial;

    repeat (3) @(negedge clk);
    checkOutput("reset_jtdo", 32'(jtdo), 32'd1);
    checkOutput("reset_rx_empty", 32'(rxEmpty), 32'd1);
    checkOutput("reset_tx_fill", 32'(txFill), 32'd0);
    checkOutput("reset_tx_full", 32'(txFull), 32'd0);
    checkOutput("reset_rx_data", 32'(rxData), 32'd0);
    checkOutput("reset_ovf", 32'(rxOverflow), 32'd0);
    @(negedge clk); resetN = 1'b1;

    $display("[TB] single RX frame and flag-0 frame");
    doCapture();
    hostFrame({8'hA5, 1'b1}, 1'b1, "rx_a5");
    rxCheckPop("rx_a5");
    d = 8'($urandom);
    hostFrame({d, 1'b0}, 1'b1, "rx_flag0");
    rxCheckPop("rx_flag0");

    $display("[TB] TX streaming");
    txWrite(8'h3C, "tx_w0");
    txWrite(8'hC3, "tx_w1");
    doCapture();
    checkOutput("tx_fill_after_capture", 32'(txFill), txModel.size());
    for (int i = 0; i < 3; i++) hostFrame('0, 1'b1, $sformatf("tx_stream%0d", i));

    $display("[TB] random mixed traffic");
    doCapture();
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 1) txWrite(8'($urandom), $sformatf("rnd_w%0d", i));
      d = 8'($urandom);
      hostFrame({d, 1'($urandom_range(0, 1))}, 1'b1, $sformatf("rnd_f%0d", i));
      rxCheckPop($sformatf("rnd_r%0d", i));
    end
    while (txModel.size() > 0) hostFrame('0, 1'b1, "rnd_drain");

    $display("[TB] RX overflow");
    doCapture();
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = 8'($urandom);
      hostFrame({d, 1'b1}, 1'b1, $sformatf("ovf_f%0d", i));
    end
    checkOutput("ovf_set", 32'(rxOverflow), 32'(ovfModel));
    for (int i = 0; i < DEPTH; i++) rxCheckPop($sformatf("ovf_r%0d", i));
    rxCheckPop("ovf_empty");
    @(negedge clk); rxOvclr = 1'b1;
    @(negedge clk); rxOvclr = 1'b0; ovfModel = 1'b0;
    checkOutput("ovf_cleared", 32'(rxOverflow), 32'(ovfModel));

    $display("[TB] abort mid-frame");
    doCapture();
    partial = {8'hE7, 1'b1};
    for (int i = 0; i < 4; i++) applyStimulus(partial[i], 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    hostFrame({8'h11, 1'b1}, 1'b0, "abort");
    rxCheckPop("abort_r0");
    rxCheckPop("abort_r1");

    $display("[TB] FIFO boundaries");
    for (int i = 0; i < DEPTH + 1; i++) txWrite(8'($urandom), $sformatf("full_w%0d", i));
    @(negedge clk); rxRd = 1'b1;
    @(negedge clk); rxRd = 1'b0;
    checkOutput("rd_empty_noop", 32'(rxEmpty), 32'd1);
    doCapture();
    for (int i = 0; i < DEPTH; i++) hostFrame('0, 1'b1, $sformatf("full_drain%0d", i));
    captureWithWrite(8'h96);
    checkOutput("rdwr_empty_fill", 32'(txFill), txModel.size());
    hostFrame('0, 1'b1, "rdwr_f0");
    hostFrame('0, 1'b1, "rdwr_f1");

    $display("[TB] asynchronous reset mid-shift");
    txWrite(8'h50, "pre_w0");
    txWrite(8'h66, "pre_w1");
    doCapture();
    hostFrame({8'h77, 1'b1}, 1'b1, "pre_f");
    txWrite(8'h12, "pre_w2");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("pre_reset_jtdo", 32'(jtdo), 32'(expFrame[4]));
    #2 resetN = 1'b0;
    #1;
    checkOutput("midrst_jtdo", 32'(jtdo), 32'd1);
    checkOutput("midrst_rx_empty", 32'(rxEmpty), 32'd1);
    checkOutput("midrst_tx_fill", 32'(txFill), 32'd0);
    checkOutput("midrst_ovf", 32'(rxOverflow), 32'd0);
    txModel.delete();
    rxModel.delete();
    ovfModel = 1'b0;
    @(negedge clk); resetN = 1'b1;
    doCapture();
    d = 8'($urandom);
    hostFrame({d, 1'b1}, 1'b1, "post_rst");
    rxCheckPop("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
